// File: rtl/store_unit.sv
// store_unit: store-side memory-stage helper.
// Takes one store per in_valid_i/in_ready_o handshake, checks its alignment,
// and turns each aligned store into a byte-strobed, lane-shifted 64-bit
// data-bus write. The write is held on the bus until dresp_data_ok_i, then
// done_o pulses for one cycle. A misaligned store never reaches the bus; it
// completes at once with done_o and misalign_o both set.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   in_valid_i          store request from the MEM stage
//   in_ready_o          high exactly while idle
//   addr_i, wdata_i     byte address, right-aligned store data
//   msize_i             access size (MSIZE1/2/4/8)
//   dreq_*_o            data-bus write request (valid, addr, size, strobe, data)
//   dresp_data_ok_i     bus write completed this cycle
//   done_o, misalign_o  registered completion pulse and its fault qualifier
//
// Parameter ZERO_UNUSED: 1 forces byte lanes whose strobe bit is 0 to zero
// on dreq_data_o; 0 leaves the shifted write data unmasked.
//
// state | meaning
// IDLE  | no store outstanding, ready to accept
// REQ   | aligned store presented on the bus, waiting for dresp_data_ok_i

package store_unit_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

module store_unit
  import store_unit_pkg::*;
#(
  parameter bit ZERO_UNUSED = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  msize_t      msize_i,
  output logic        dreq_valid_o,
  output logic [63:0] dreq_addr_o,
  output msize_t      dreq_size_o,
  output logic [7:0]  dreq_strobe_o,
  output logic [63:0] dreq_data_o,
  input  logic        dresp_data_ok_i,
  output logic        done_o,
  output logic        misalign_o
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  msize_t      size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] data_q, data_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;

  logic [2:0]  lane;
  logic        is_misaligned;
  logic [7:0]  strobe_new;
  logic [63:0] shifted;
  logic [63:0] data_new;

  assign lane = addr_i[2:0];

  always_comb begin
    is_misaligned = 1'b0;
    strobe_new    = 8'h00;
    unique case (msize_i)
      MSIZE1: begin
        strobe_new = 8'h01 << lane;
      end
      MSIZE2: begin
        is_misaligned = lane[0];
        strobe_new    = 8'h03 << lane;
      end
      MSIZE4: begin
        is_misaligned = |lane[1:0];
        strobe_new    = 8'h0F << lane;
      end
      MSIZE8: begin
        is_misaligned = |lane;
        strobe_new    = 8'hFF;
      end
      default: begin
        is_misaligned = 1'b0;
        strobe_new    = 8'h00;
      end
    endcase
  end

  // Bytes shifted past lane 7 fall off the top of the bus word.
  assign shifted = wdata_i << {lane, 3'b000};

  always_comb begin
    data_new = shifted;
    if (ZERO_UNUSED) begin
      for (int i = 0; i < 8; i++) begin
        if (!strobe_new[i]) begin
          data_new[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    strobe_d   = strobe_q;
    data_d     = data_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (is_misaligned) begin
            // Faulted store completes immediately; bus registers untouched.
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            addr_d   = addr_i;
            size_d   = msize_i;
            strobe_d = strobe_new;
            data_d   = data_new;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (dresp_data_ok_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= MSIZE1;
      strobe_q   <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      data_q     <= data_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  assign in_ready_o    = (state_q == IDLE);
  assign dreq_valid_o  = (state_q == REQ);
  assign dreq_addr_o   = addr_q;
  assign dreq_size_o   = size_q;
  assign dreq_strobe_o = strobe_q;
  assign dreq_data_o   = data_q;
  assign done_o        = done_q;
  assign misalign_o    = misalign_q;

endmodule
